multi_port_queue: RTL and testbench

- Parametrised circular FIFO for superscalar front-end/back-end buffering, e.g. fetch-to-decode or decode-to-dispatch instruction queues.
- Accepts up to ENQ_WIDTH entries and delivers up to DEQ_WIDTH entries per cycle.
- Read path is first-word fall-through: head entries are visible combinationally, with per-lane valid/ready handshakes.
- Supports a single-cycle flush for branch-mispredict recovery and exports an occupancy count for dispatch throttling.

---
 rtl/multi_port_queue.sv | 118 +++++++++++
 tb/tb_multi_port_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_queue.sv
// Multi-lane circular FIFO with first-word fall-through read lanes, single-cycle
// flush and an occupancy count. Pointers carry a wrap bit to separate full from empty.
module multi_port_queue #(
    parameter int NUM_ENTRIES = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int ENQ_WIDTH   = 2,
    parameter int DEQ_WIDTH   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [ENQ_WIDTH-1:0]                  enq_valid,
    input  logic [ENQ_WIDTH-1:0][DATA_WIDTH-1:0]  enq_wdata,
    output logic                                  enq_ready,
    output logic [DEQ_WIDTH-1:0]                  deq_valid,
    output logic [DEQ_WIDTH-1:0][DATA_WIDTH-1:0]  deq_rdata,
    input  logic [DEQ_WIDTH-1:0]                  deq_ready,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]      count,
    output logic                                  full,
    output logic                                  empty
);

    localparam int Q_INDEX = $clog2(NUM_ENTRIES);
    localparam int PTR_W   = Q_INDEX + 1;
    localparam int CNT_W   = $clog2(NUM_ENTRIES + 1);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUM_ENTRIES);

    logic [DATA_WIDTH-1:0] entries [NUM_ENTRIES];

    logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
    logic [PTR_W-1:0] tail_ptr_reg, tail_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] n_enq, n_deq;
    logic [CNT_W-1:0] free_slots;
    logic [Q_INDEX-1:0] wr_idx [ENQ_WIDTH];

    // Readiness looks only at current occupancy, so slots freed this cycle wait a cycle.
    assign free_slots = DEPTH - count_reg;
    assign enq_ready  = free_slots >= CNT_W'(ENQ_WIDTH);
    assign count      = count_reg;
    assign full       = (count_reg == DEPTH);
    assign empty      = (count_reg == '0);

    genvar gi;
    generate
        for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq
            assign wr_idx[gi] = tail_ptr_reg[Q_INDEX-1:0] + Q_INDEX'(gi);
        end

        for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
            logic [Q_INDEX-1:0] rd_idx;
            assign rd_idx        = head_ptr_reg[Q_INDEX-1:0] + Q_INDEX'(gi);
            assign deq_valid[gi] = count_reg > CNT_W'(gi);
            assign deq_rdata[gi] = deq_valid[gi] ? entries[rd_idx] : '0;
        end
    endgenerate

    always_comb begin
        n_enq = '0;
        n_deq = '0;
        if (enq_ready) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (enq_valid[i]) begin
                    n_enq = n_enq + CNT_W'(1);
                end
            end
        end
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            if (deq_valid[j] && deq_ready[j]) begin
                n_deq = n_deq + CNT_W'(1);
            end
        end
        head_ptr_next = head_ptr_reg + PTR_W'(n_deq);
        tail_ptr_next = tail_ptr_reg + PTR_W'(n_enq);
        count_next    = count_reg + n_enq - n_deq;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr_reg <= '0;
            tail_ptr_reg <= '0;
            count_reg    <= '0;
        end else begin
            head_ptr_reg <= head_ptr_next;
            tail_ptr_reg <= tail_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Array contents need no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq_ready) begin
            for (int i = 0; i < ENQ_WIDTH; i++) begin
                if (enq_valid[i]) begin
                    entries[wr_idx[i]] <= enq_wdata[i];
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic [ENQ_WIDTH-1:0] enq_valid_inc;
    logic [DEQ_WIDTH-1:0] deq_ready_inc;
    assign enq_valid_inc = enq_valid + ENQ_WIDTH'(1);
    assign deq_ready_inc = deq_ready + DEQ_WIDTH'(1);

    // A prefix mask plus one is a power of two, so the AND must be zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((enq_valid & enq_valid_inc) == '0);
            assert ((deq_ready & deq_ready_inc) == '0);
            assert ((deq_ready & ~deq_valid) == '0);
            assert (PTR_W'(tail_ptr_reg - head_ptr_reg) == PTR_W'(count_reg));
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_queue.sv
// Bench for multi_port_queue: directed scenarios plus randomized traffic checked
// against a plain queue model of the FIFO contents.
module tb_multi_port_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       enq_valid;
    logic [1:0][31:0] enq_wdata;
    logic             enq_ready;
    logic [1:0]       deq_valid;
    logic [1:0][31:0] deq_rdata;
    logic [1:0]       deq_ready;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    logic [31:0] model_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    multi_port_queue #(
        .NUM_ENTRIES(8),
        .DATA_WIDTH (32),
        .ENQ_WIDTH  (2),
        .DEQ_WIDTH  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .enq_valid(enq_valid),
        .enq_wdata(enq_wdata),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid),
        .deq_rdata(deq_rdata),
        .deq_ready(deq_ready),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Apply one cycle of inputs, clock it, and advance the reference queue.
    task automatic cycle(input logic r, input logic fl, input logic [1:0] ev,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] dr);
        int npop;
        bit rdy;
        rst          = r;
        flush        = fl;
        enq_valid    = ev;
        enq_wdata[0] = d0;
        enq_wdata[1] = d1;
        deq_ready    = dr;
        rdy  = (8 - model_q.size()) >= 2;
        npop = (dr == 2'b11) ? 2 : (dr == 2'b01) ? 1 : 0;
        if (npop > model_q.size()) npop = model_q.size();
        @(posedge clk);
        #1;
        cyc++;
        if (r || fl) begin
            model_q.delete();
        end else begin
            repeat (npop) void'(model_q.pop_front());
            if (rdy) begin
                if (ev[0]) model_q.push_back(d0);
                if (ev[1]) model_q.push_back(d1);
            end
        end
        $display("txn %0d: rst=%0b flush=%0b enq_valid=%b deq_ready=%b -> count=%0d",
                 cyc, r, fl, ev, dr, count);
        rst       = 1'b0;
        flush     = 1'b0;
        enq_valid = 2'b00;
        deq_ready = 2'b00;
    endtask

    task automatic test_reset();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
        n_cmp++; if (deq_valid !== 2'b00) begin n_fail++; $display("FAIL reset_deq_valid: got %b want 00", deq_valid); end
        n_cmp++; if (deq_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_deq_rdata: got %h want 0", deq_rdata); end
    endtask

    task automatic test_basic();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        cycle(0, 0, 2'b11, 32'hA, 32'hB, 2'b00);
        n_cmp++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", count); end
        n_cmp++; if (deq_valid !== 2'b11) begin n_fail++; $display("FAIL basic_deq_valid: got %b want 11", deq_valid); end
        n_cmp++; if (deq_rdata[0] !== 32'hA) begin n_fail++; $display("FAIL basic_rdata0: got %h want a", deq_rdata[0]); end
        n_cmp++; if (deq_rdata[1] !== 32'hB) begin n_fail++; $display("FAIL basic_rdata1: got %h want b", deq_rdata[1]); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", empty); end
    endtask

    task automatic test_full();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        for (int k = 0; k < 4; k++) cycle(0, 0, 2'b11, 32'(2*k+1), 32'(2*k+2), 2'b00);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", count); end
        n_cmp++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_enq_ready: got %b want 0", enq_ready); end
        cycle(0, 0, 2'b11, 32'hF, 32'hF, 2'b00);
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_reject_count: got %0d want 8", count); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (deq_rdata[0] !== 32'(2*k+1) || deq_rdata[1] !== 32'(2*k+2)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: got %h,%h want %h,%h", k, deq_rdata[0], deq_rdata[1], 2*k+1, 2*k+2);
            end
            cycle(0, 0, 2'b00, 0, 0, 2'b11);
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty: got %b want 1", empty); end
    endtask

    task automatic test_almost_full();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b11, 32'h30 + 32'(k), 32'h40 + 32'(k), 2'b00);
        cycle(0, 0, 2'b01, 32'h50, 32'h0, 2'b00);
        n_cmp++; if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL af_enq_ready7: got %b want 0", enq_ready); end
        cycle(0, 0, 2'b01, 32'h77, 32'h0, 2'b00);
        n_cmp++; if (count !== 4'd7) begin n_fail++; $display("FAIL af_reject_count: got %0d want 7", count); end
        cycle(0, 0, 2'b00, 0, 0, 2'b01);
        n_cmp++; if (count !== 4'd6) begin n_fail++; $display("FAIL af_pop_count: got %0d want 6", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL af_enq_ready6: got %b want 1", enq_ready); end
        cycle(0, 0, 2'b11, 32'h61, 32'h62, 2'b00);
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL af_refill_count: got %0d want 8", count); end
        n_cmp++; if (deq_rdata[0] !== 32'h40) begin n_fail++; $display("FAIL af_head: got %h want 40", deq_rdata[0]); end
    endtask

    task automatic test_wrap();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b11, 32'h10 + 32'(k), 32'h20 + 32'(k), 2'b00);
        for (int k = 0; k < 3; k++) cycle(0, 0, 2'b00, 0, 0, 2'b11);
        cycle(0, 0, 2'b11, 32'hC0, 32'hC1, 2'b00);
        cycle(0, 0, 2'b11, 32'hC2, 32'hC3, 2'b00);
        n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", count); end
        n_cmp++; if (deq_rdata[0] !== 32'hC0) begin n_fail++; $display("FAIL wrap_rdata0: got %h want c0", deq_rdata[0]); end
        n_cmp++; if (deq_rdata[1] !== 32'hC1) begin n_fail++; $display("FAIL wrap_rdata1: got %h want c1", deq_rdata[1]); end
        cycle(0, 0, 2'b00, 0, 0, 2'b11);
        n_cmp++; if (deq_rdata[0] !== 32'hC2) begin n_fail++; $display("FAIL wrap_rdata0b: got %h want c2", deq_rdata[0]); end
        n_cmp++; if (deq_rdata[1] !== 32'hC3) begin n_fail++; $display("FAIL wrap_rdata1b: got %h want c3", deq_rdata[1]); end
    endtask

    task automatic test_simultaneous();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        cycle(0, 0, 2'b11, 32'h51, 32'h52, 2'b00);
        cycle(0, 0, 2'b01, 32'h53, 32'h0, 2'b00);
        cycle(0, 0, 2'b11, 32'h54, 32'h55, 2'b11);
        n_cmp++; if (count !== 4'd3) begin n_fail++; $display("FAIL simul_count: got %0d want 3", count); end
        n_cmp++; if (deq_rdata[0] !== 32'h53) begin n_fail++; $display("FAIL simul_rdata0: got %h want 53", deq_rdata[0]); end
        n_cmp++; if (deq_rdata[1] !== 32'h54) begin n_fail++; $display("FAIL simul_rdata1: got %h want 54", deq_rdata[1]); end
        cycle(0, 0, 2'b00, 0, 0, 2'b11);
        n_cmp++; if (deq_rdata[0] !== 32'h55) begin n_fail++; $display("FAIL simul_tail: got %h want 55", deq_rdata[0]); end
        n_cmp++; if (deq_valid !== 2'b01) begin n_fail++; $display("FAIL simul_deq_valid: got %b want 01", deq_valid); end
    endtask

    task automatic test_flush();
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        cycle(0, 0, 2'b11, 32'h1, 32'h2, 2'b00);
        cycle(0, 0, 2'b11, 32'h3, 32'h4, 2'b00);
        cycle(0, 0, 2'b01, 32'h5, 32'h0, 2'b00);
        n_cmp++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", count); end
        cycle(0, 1, 2'b11, 32'h6, 32'h7, 2'b11);
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty); end
        n_cmp++; if (deq_valid !== 2'b00) begin n_fail++; $display("FAIL flush_deq_valid: got %b want 00", deq_valid); end
        n_cmp++; if (deq_rdata !== 64'h0) begin n_fail++; $display("FAIL flush_deq_rdata: got %h want 0", deq_rdata); end
        cycle(0, 0, 2'b11, 32'h8, 32'h9, 2'b00);
        cycle(0, 0, 2'b11, 32'hA, 32'hB, 2'b00);
        cycle(1, 0, 2'b11, 32'hC, 32'hD, 2'b11);
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got empty=%b full=%b want 1,0", empty, full); end
        n_cmp++; if (deq_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_mid_deq_rdata: got %h want 0", deq_rdata); end
    endtask

    task automatic test_random();
        logic        r, fl;
        logic [1:0]  ev, dr;
        int          k;
        logic [31:0] exp_rd;
        cycle(1, 0, 2'b00, 0, 0, 2'b00);
        for (int t = 0; t < 400; t++) begin
            r  = ($urandom_range(0, 199) == 0);
            fl = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 2))
                0:       ev = 2'b00;
                1:       ev = 2'b01;
                default: ev = 2'b11;
            endcase
            k = $urandom_range(0, 2);
            if (k > model_q.size()) k = model_q.size();
            dr = (k == 2) ? 2'b11 : (k == 1) ? 2'b01 : 2'b00;
            cycle(r, fl, ev, $urandom, $urandom, dr);
            n_cmp++;
            if (count !== 4'(model_q.size())) begin
                n_fail++; $display("FAIL rand_count t=%0d: got %0d want %0d", t, count, model_q.size());
            end
            n_cmp++;
            if (full !== (model_q.size() == 8) || empty !== (model_q.size() == 0)) begin
                n_fail++; $display("FAIL rand_flags t=%0d: got full=%b empty=%b size %0d", t, full, empty, model_q.size());
            end
            n_cmp++;
            if (enq_ready !== ((8 - model_q.size()) >= 2)) begin
                n_fail++; $display("FAIL rand_enq_ready t=%0d: got %b size %0d", t, enq_ready, model_q.size());
            end
            for (int j = 0; j < 2; j++) begin
                exp_rd = (j < model_q.size()) ? model_q[j] : 32'h0;
                n_cmp++;
                if (deq_valid[j] !== (j < model_q.size())) begin
                    n_fail++; $display("FAIL rand_deq_valid%0d t=%0d: got %b size %0d", j, t, deq_valid[j], model_q.size());
                end
                n_cmp++;
                if (deq_rdata[j] !== exp_rd) begin
                    n_fail++; $display("FAIL rand_rdata%0d t=%0d: got %h want %h", j, t, deq_rdata[j], exp_rd);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        enq_valid = 2'b00;
        enq_wdata = '0;
        deq_ready = 2'b00;
        test_reset();
        test_basic();
        test_full();
        test_almost_full();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
